// File: rtl/keypad_scan.sv
// 4x4 key matrix scanner: drives one row low at a time, debounces whole-matrix
// frames and reports each new press as a 4-bit code under a valid/ack handshake.
module keypad_scan #(
  parameter int SCAN_PERIOD = 1000,
  parameter int DEBOUNCE    = 5
) (
  input  logic        clkus,
  input  logic        rst,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic [3:0]  key,
  output logic        key_valid,
  input  logic        key_ack,
  output logic [15:0] keys_down,
  output logic        overrun
);

  localparam int             CW         = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam logic [CW-1:0]  CNT_LAST   = CW'(SCAN_PERIOD - 1);
  localparam logic [3:0]     STABLE_MAX = 4'(DEBOUNCE);
  localparam logic [1:0]     ROW_LAST   = 2'd3;

  logic [3:0]    col_meta_q, col_sync_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    row_idx_q;
  logic [3:0]    row_q;
  logic [15:0]   frame_q, prev_q, keys_down_q;
  logic [3:0]    stable_q;
  logic [3:0]    key_q;
  logic          key_valid_q, overrun_q;

  logic          sample, frame_end, accept, press_evt;
  logic [15:0]   frame_d, new_press;
  logic [3:0]    stable_d, code_d;

  // frame_d merges the live row into the stored frame, so at frame end it is
  // the completed frame including row 3.
  always_comb begin
    sample    = (cnt_q == CNT_LAST);
    frame_end = sample && (row_idx_q == ROW_LAST);
    frame_d   = frame_q;
    frame_d[{row_idx_q, 2'b00} +: 4] = ~col_sync_q;

    if (frame_d != prev_q)         stable_d = 4'd1;
    else if (stable_q >= STABLE_MAX) stable_d = STABLE_MAX;
    else                           stable_d = stable_q + 4'd1;

    accept    = frame_end && (stable_d == STABLE_MAX) && (frame_d != keys_down_q);
    new_press = frame_d & ~keys_down_q;
    press_evt = accept && (|new_press);

    // Lowest set bit wins; the other new presses are silently absorbed.
    code_d = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (new_press[i]) code_d = 4'(i);
    end
  end

  always_ff @(posedge clkus) begin
    if (rst) begin
      col_meta_q  <= 4'b1111;
      col_sync_q  <= 4'b1111;
      cnt_q       <= '0;
      row_idx_q   <= 2'd0;
      row_q       <= 4'b1110;
      frame_q     <= '0;
      prev_q      <= '0;
      stable_q    <= 4'd0;
      keys_down_q <= '0;
      key_q       <= 4'd0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      col_meta_q <= col;
      col_sync_q <= col_meta_q;

      if (sample) begin
        cnt_q     <= '0;
        row_idx_q <= row_idx_q + 2'd1;
        row_q     <= {row_q[2:0], row_q[3]};
        frame_q   <= frame_d;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (frame_end) begin
        prev_q   <= frame_d;
        stable_q <= stable_d;
      end
      if (accept) keys_down_q <= frame_d;

      // valid/ack: key holds while key_valid is high; ack only counts when
      // key_valid is high, and an ack on the event cycle frees the slot.
      if (press_evt) begin
        if (!key_valid_q || key_ack) begin
          key_q       <= code_d;
          key_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (key_valid_q && key_ack) begin
        key_valid_q <= 1'b0;
      end
    end
  end

  assign row       = row_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign keys_down = keys_down_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural 4x4 switch matrix
// (SCAN_PERIOD=8, DEBOUNCE=3, one frame = 32 cycles).
module tb_keypad_scan;
  localparam int SP = 8;
  localparam int DB = 3;
  localparam int FR = 4 * SP;

  logic        clkus = 1'b0;
  logic        rst = 1'b1;
  logic        key_ack = 1'b0;
  logic [3:0]  col, row, key;
  logic        key_valid, overrun;
  logic [15:0] keys_down;
  logic [15:0] mask = '0;

  int cyc = 0, last_rst = 0;
  int n_checks = 0, n_pass = 0;
  int lat, start;
  bit ok;

  keypad_scan #(.SCAN_PERIOD(SP), .DEBOUNCE(DB)) dut (
    .clkus(clkus), .rst(rst), .col(col), .row(row), .key(key),
    .key_valid(key_valid), .key_ack(key_ack), .keys_down(keys_down),
    .overrun(overrun)
  );

  always #5 clkus = ~clkus;

  // Edge index bookkeeping: after edge n, cyc == n; last_rst is the last reset edge.
  always @(posedge clkus) begin
    cyc <= cyc + 1;
    if (rst) last_rst <= cyc + 1;
  end

  // A closed switch pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && mask[r*4+c]) col[c] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_valid(input int maxc, output int n, output bit got);
    got = 1'b0;
    n   = 0;
    while (n < maxc && !got) begin
      @(negedge clkus);
      n++;
      if (key_valid) got = 1'b1;
    end
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    @(negedge clkus);
    key_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clkus);
    rst = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset and row stepping
    mask = '0;
    do_reset();
    chk("rst_row", row, 4'b1110);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_keys_down", keys_down, 16'h0000);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_key", key, 4'd0);
    while (cyc != last_rst + 7) @(negedge clkus);
    chk("row_hold_7", row, 4'b1110);
    @(negedge clkus);
    chk("row_step_8", row, 4'b1101);
    ack_pulse();
    chk("idle_ack_ignored", key_valid, 1'b0);

    // 2. Single press of key 6
    mask = 16'h0040;
    wait_valid(5 * FR, lat, ok);
    chk("k6_timeout", ok, 1'b1);
    chk("k6_latency", (lat >= 2 * FR && lat <= 4 * FR + 3), 1'b1);
    chk("k6_key", key, 4'd6);
    chk("k6_keys_down", keys_down, 16'h0040);
    ack_pulse();
    chk("k6_ack_clears", key_valid, 1'b0);
    mask = '0;
    repeat (5 * FR) @(negedge clkus);
    chk("k6_release_down", keys_down, 16'h0000);
    chk("k6_release_noevt", key_valid, 1'b0);

    // 3. Bouncing key 9, then held
    for (int i = 0; i < 6; i++) begin
      mask = (i % 2 == 0) ? 16'h0200 : 16'h0000;
      repeat (FR) @(negedge clkus);
      chk($sformatf("bounce_%0d_valid", i), key_valid, 1'b0);
    end
    mask = 16'h0200;
    wait_valid(5 * FR, lat, ok);
    chk("k9_timeout", ok, 1'b1);
    chk("k9_key", key, 4'd9);
    chk("k9_keys_down", keys_down, 16'h0200);
    ack_pulse();
    repeat (5 * FR) @(negedge clkus);
    chk("k9_single_report", key_valid, 1'b0);
    mask = '0;
    repeat (5 * FR) @(negedge clkus);

    // 4. Overrun: key 3 unacknowledged, then key 12
    mask = 16'h0008;
    wait_valid(5 * FR, lat, ok);
    chk("k3_timeout", ok, 1'b1);
    chk("k3_key", key, 4'd3);
    mask = '0;
    repeat (5 * FR) @(negedge clkus);
    mask = 16'h1000;
    repeat (5 * FR) @(negedge clkus);
    chk("ovr_key", key, 4'd3);
    chk("ovr_valid", key_valid, 1'b1);
    chk("ovr_flag", overrun, 1'b1);
    chk("ovr_keys_down", keys_down, 16'h1000);
    ack_pulse();
    chk("ovr_ack_valid", key_valid, 1'b0);
    chk("ovr_sticky", overrun, 1'b1);
    mask = '0;
    repeat (5 * FR) @(negedge clkus);
    chk("ovr_still_sticky", overrun, 1'b1);
    do_reset();
    chk("ovr_rst_clears", overrun, 1'b0);
    chk("ovr_rst_row", row, 4'b1110);

    // 5. Simultaneous keys 5 and 10
    mask = 16'h0420;
    wait_valid(6 * FR, lat, ok);
    chk("k5k10_timeout", ok, 1'b1);
    chk("k5k10_key", key, 4'd5);
    chk("k5k10_keys_down", keys_down, 16'h0420);
    chk("k5k10_no_overrun", overrun, 1'b0);
    ack_pulse();
    mask = 16'h0400;
    repeat (5 * FR) @(negedge clkus);
    chk("k5_release_down", keys_down, 16'h0400);
    chk("k5_release_noevt", key_valid, 1'b0);
    mask = 16'h0420;
    wait_valid(5 * FR, lat, ok);
    chk("k5_repress_timeout", ok, 1'b1);
    chk("k5_repress_key", key, 4'd5);
    ack_pulse();
    mask = '0;
    repeat (5 * FR) @(negedge clkus);
    chk("k5k10_all_up", keys_down, 16'h0000);

    // 6. Ack on the exact accept cycle of key 14
    mask = 16'h0002;
    wait_valid(5 * FR, lat, ok);
    chk("k1_timeout", ok, 1'b1);
    chk("k1_key", key, 4'd1);
    mask = '0;
    repeat (5 * FR) @(negedge clkus);
    chk("k1_up", keys_down, 16'h0000);
    chk("k1_still_pending", key_valid, 1'b1);
    while ((cyc - last_rst) % FR != 0) @(negedge clkus);
    start = cyc;
    mask = 16'h4000;
    while (cyc != start + 3 * FR - 1) @(negedge clkus);
    chk("coll_pre_down", keys_down, 16'h0000);
    chk("coll_pre_key", key, 4'd1);
    ack_pulse();
    chk("coll_key", key, 4'd14);
    chk("coll_valid", key_valid, 1'b1);
    chk("coll_overrun", overrun, 1'b0);
    chk("coll_keys_down", keys_down, 16'h4000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
